dsp_sequencer: RTL and testbench
================================

// Module: dsp_sequencer
// PURPOSE
//  Instruction sequencer directly upstream of dsp_core; drives its instruction input.
//  Holds the per-sample microprogram in an internal program RAM, loaded by the host.
//  On each sample_tick it issues words 0..L-1 in order, then NOPs while the core pipeline drains.
//  Raises frame_done when the frame's writebacks are complete; flags overruns.
// PARAMETERS
//  OPCODE_WIDTH       6   opcode field width (NOP = 0)
//  SAMPLE_ADDR_WIDTH 10   sample_addr field width
//  PARAM_ADDR_WIDTH  10   param_addr field width
//  PROG_ADDR_WIDTH   10   program RAM address width; depth = 2**PROG_ADDR_WIDTH
//  PIPE_DEPTH         4   core stages after instruction port (read, ex1, ex2, writeback)
//  INSTR_WIDTH = OPCODE_WIDTH+SAMPLE_ADDR_WIDTH+PARAM_ADDR_WIDTH (localparam, 26)
// PORTS
//  clk           in   1                   sole clock, rising edge
//  reset         in   1                   asynchronous, active-high
//  sample_tick   in   1                   one-cycle frame start request
//  prog_len      in   PROG_ADDR_WIDTH+1   words per frame L, sampled on accepted tick
//  prog_wr_en    in   1                   host program write strobe
//  prog_wr_addr  in   PROG_ADDR_WIDTH     host write address
//  prog_wr_data  in   INSTR_WIDTH         host write data (instr_t)
//  overrun_clr   in   1                   clears overrun
//  instruction   out  INSTR_WIDTH         to dsp_core, registered; NOP when not issuing
//  frame_active  out  1                   high from frame accept until frame_done
//  frame_done    out  1                   one-cycle pulse, frame fully written back
//  overrun       out  1                   sticky: tick arrived while frame busy
//  wr_reject     out  1                   one-cycle pulse: host write dropped (not IDLE)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, pc=0, instruction=0 (NOP), frame_active=0, frame_done=0,
//   overrun=0, wr_reject=0. Program RAM contents are not reset.
//  FSM IDLE -> RUN -> DRAIN -> IDLE.
//  IDLE: instruction=NOP. Tick at edge T: L_q <= min(prog_len, 2**PROG_ADDR_WIDTH).
//   L_q=0: frame_done pulses in cycle T+1, stay IDLE, frame_active stays 0.
//   Else pc<=0, enter RUN; frame_active=1 from cycle T+1.
//  RUN: cycle T+1+k presents RAM read address k (k=0..L-1), pc++.
//   RAM read latency is 1 and the output is registered: word k appears on instruction in cycle T+2+k.
//   After address L-1, go to DRAIN.
//  DRAIN: instruction=NOP once last word is out; counter runs PIPE_DEPTH cycles.
//   frame_done=1 in cycle T+2+L+PIPE_DEPTH only, with frame_active still 1.
//   Next cycle is IDLE with frame_active=0.
//  pc counts in PROG_ADDR_WIDTH+1 bits; L=2**PROG_ADDR_WIDTH issues every word, with no wrap to 0.
//  Tick while RUN/DRAIN, or in the frame_done cycle: ignored, overrun<=1.
//   Set and overrun_clr in the same cycle: set wins.
//  Host writes are committed only in IDLE; otherwise dropped and wr_reject pulses the next cycle.
//   A write and a tick in the same IDLE cycle: write commits and the frame starts.
//   The frame reads the new data, since the first read is at T+1.
//  prog_len changes after acceptance have no effect on the running frame.
//  Reset mid-frame: immediate return to reset values; no frame_done is emitted.
// STRUCTURE
//  dsp_pkg: opcode_t, instr_t, NOP constant, field-width localparams; shared with dsp_core.
//  Sub-module prog_ram: simple dual-port sync RAM (1 write, 1 read port).
//   Registered read, no reset, inferable as block RAM.
//  Sequencer holds the FSM, pc, drain counter, status flags, and the output NOP mux register.
// TESTING
//  Reset: assert reset mid-RUN -> outputs 0 the same cycle.
//   No frame_done; next tick starts cleanly from word 0.
//  Frame: load words 0..2 = {MUL,5,7},{MAC,6,8},{STORE,9,0}, L=3, tick at T ->
//   instruction = words 0..2 in T+2..T+4, NOP after, frame_done at T+9.
//  Zero length: L=0, tick -> frame_done at T+1, instruction stays NOP, frame_active never 1.
//  Overrun: L=3, second tick at T+4 -> ignored, overrun=1; overrun_clr+tick together -> overrun stays 1.
//  Host writes: write in RUN -> wr_reject pulse, RAM unchanged.
//   Write to addr 0 plus tick in IDLE -> new word 0 issued at T+2.
//  Full depth: fill 1024 words with sample_addr=index, prog_len=1500 ->
//   1024 words 0..1023 issued, no wrap, frame_done at T+1030.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared instruction format for dsp_sequencer and dsp_core: opcode set, packed instruction word,
// the NOP constant and the sequencer state encoding.
package dsp_pkg;

  localparam int OPCODE_W      = 6;
  localparam int SAMPLE_ADDR_W = 10;
  localparam int PARAM_ADDR_W  = 10;
  localparam int INSTR_W       = OPCODE_W + SAMPLE_ADDR_W + PARAM_ADDR_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 6'd0,
    OP_MUL   = 6'd1,
    OP_MAC   = 6'd2,
    OP_ADD   = 6'd3,
    OP_STORE = 6'd4
  } opcode_t;

  typedef struct packed {
    opcode_t                  opcode;
    logic [SAMPLE_ADDR_W-1:0] sample_addr;
    logic [PARAM_ADDR_W-1:0]  param_addr;
  } instr_t;

  localparam instr_t NOP = '{opcode: OP_NOP, sample_addr: '0, param_addr: '0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } seq_state_t;

endpackage

// File: rtl/prog_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
// Written so synthesis maps it onto a block RAM.
module prog_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: no reset on the array or read register -- a reset would stop block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dsp_sequencer.sv
// Instruction sequencer feeding dsp_core: issues the loaded microprogram once per sample_tick,
// then drains the core pipeline and reports frame completion and overruns.
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter  int OPCODE_WIDTH      = OPCODE_W,
  parameter  int SAMPLE_ADDR_WIDTH = SAMPLE_ADDR_W,
  parameter  int PARAM_ADDR_WIDTH  = PARAM_ADDR_W,
  parameter  int PROG_ADDR_WIDTH   = 10,
  parameter  int PIPE_DEPTH        = 4,
  localparam int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [PROG_ADDR_WIDTH:0] prog_len,
  input  logic                     prog_wr_en,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
  input  logic [INSTR_WIDTH-1:0]   prog_wr_data,
  input  logic                     overrun_clr,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     frame_active,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     wr_reject
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH);
  localparam logic [PROG_ADDR_WIDTH:0] MAX_LEN = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(NOP);

  seq_state_t               state;
  logic [PROG_ADDR_WIDTH:0] pc;
  logic [PROG_ADDR_WIDTH:0] len_q;
  logic [CNT_W-1:0]         drain_cnt;
  logic                     issue_q;
  logic [INSTR_WIDTH-1:0]   ram_q;

  logic                     tick_accept;
  logic                     ram_wr_en;
  logic                     ram_rd_en;
  logic [PROG_ADDR_WIDTH:0] len_clamped;

  // NOTE: every signal gets a value before any condition, so no latch is inferred.
  always_comb begin
    tick_accept = sample_tick && (state == S_IDLE) && !frame_done;
    ram_wr_en   = prog_wr_en && (state == S_IDLE);
    ram_rd_en   = (state == S_RUN);
    len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    instruction = issue_q ? ram_q : NOP_WORD;
  end

  prog_ram #(
    .ADDR_WIDTH(PROG_ADDR_WIDTH),
    .DATA_WIDTH(INSTR_WIDTH)
  ) u_prog_ram (
    .clk    (clk),
    .wr_en  (ram_wr_en),
    .wr_addr(prog_wr_addr),
    .wr_data(prog_wr_data),
    .rd_en  (ram_rd_en),
    .rd_addr(pc[PROG_ADDR_WIDTH-1:0]),
    .rd_data(ram_q)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      len_q        <= '0;
      drain_cnt    <= '0;
      issue_q      <= 1'b0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      wr_reject    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      issue_q    <= (state == S_RUN);
      wr_reject  <= prog_wr_en && (state != S_IDLE);

      // A tick that cannot start a frame beats a simultaneous clear.
      if (sample_tick && !tick_accept) overrun <= 1'b1;
      else if (overrun_clr)            overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick_accept) begin
            len_q <= len_clamped;
            pc    <= '0;
            if (len_clamped == '0) begin
              frame_done <= 1'b1;
            end else begin
              state        <= S_RUN;
              frame_active <= 1'b1;
            end
          end
        end
        S_RUN: begin
          pc <= pc + 1'b1;
          if (pc + 1'b1 == len_q) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          // Stay here through the frame_done cycle so a tick there still counts as an overrun.
          if (frame_done) begin
            state        <= S_IDLE;
            frame_active <= 1'b0;
          end else if (drain_cnt == DRAIN_LAST) begin
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: table-driven frame vectors plus hand-written
// sequences for host-write, reset and full-depth corner cases.
module tb_dsp_sequencer;
  import dsp_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic [10:0]   prog_len;
  logic          prog_wr_en;
  logic [9:0]    prog_wr_addr;
  logic [25:0]   prog_wr_data;
  logic          overrun_clr;
  logic [25:0]   instruction;
  logic          frame_active;
  logic          frame_done;
  logic          overrun;
  logic          wr_reject;

  dsp_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .prog_len    (prog_len),
    .prog_wr_en  (prog_wr_en),
    .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data),
    .overrun_clr (overrun_clr),
    .instruction (instruction),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .wr_reject   (wr_reject)
  );

  always #5 clk = ~clk;

  // One row per cycle T+j: expected outputs of that cycle, then inputs sampled at edge T+j.
  typedef struct {
    logic        tick;
    logic        clr;
    logic [10:0] len;
    instr_t      exp_instr;
    logic        exp_active;
    logic        exp_done;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_t w0, w1, w2, new0, junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic instr_t mk(opcode_t op, int s, int p);
    mk = '{opcode: op, sample_addr: 10'(s), param_addr: 10'(p)};
  endfunction

  function automatic void add(logic tick, logic clr, logic [10:0] len, instr_t ins,
                              logic act, logic done, logic ovr);
    vec_t v;
    v.tick = tick; v.clr = clr; v.len = len; v.exp_instr = ins;
    v.exp_active = act; v.exp_done = done; v.exp_ovr = ovr;
    vecs.push_back(v);
  endfunction

  task automatic run_vecs(input string tag);
    for (int j = 0; j < vecs.size(); j++) begin
      @(negedge clk);
      check($sformatf("%s[%0d].instruction", tag, j), 32'(instruction), 32'(vecs[j].exp_instr));
      check($sformatf("%s[%0d].frame_active", tag, j), 32'(frame_active), 32'(vecs[j].exp_active));
      check($sformatf("%s[%0d].frame_done", tag, j), 32'(frame_done), 32'(vecs[j].exp_done));
      check($sformatf("%s[%0d].overrun", tag, j), 32'(overrun), 32'(vecs[j].exp_ovr));
      sample_tick = vecs[j].tick;
      overrun_clr = vecs[j].clr;
      prog_len    = vecs[j].len;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    vecs.delete();
  endtask

  task automatic write_word(input int addr, input instr_t w);
    @(negedge clk);
    prog_wr_en   = 1'b1;
    prog_wr_addr = 10'(addr);
    prog_wr_data = w;
    @(negedge clk);
    prog_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     err_cnt;
    int     first_done;
    logic   done_seen;
    logic   active_after;
    instr_t exp_w;

    w0   = mk(OP_MUL, 5, 7);
    w1   = mk(OP_MAC, 6, 8);
    w2   = mk(OP_STORE, 9, 0);
    new0 = mk(OP_ADD, 1, 2);
    junk = mk(OP_ADD, 1023, 1023);

    reset = 1'b1; sample_tick = 1'b0; prog_len = 11'd0; prog_wr_en = 1'b0;
    prog_wr_addr = '0; prog_wr_data = '0; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.instruction", 32'(instruction), 32'(NOP));
    check("reset.frame_active", 32'(frame_active), 32'd0);
    check("reset.frame_done", 32'(frame_done), 32'd0);
    check("reset.overrun", 32'(overrun), 32'd0);
    check("reset.wr_reject", 32'(wr_reject), 32'd0);
    reset = 1'b0;

    write_word(0, w0);
    write_word(1, w1);
    write_word(2, w2);

    // Basic L=3 frame; prog_len changes after acceptance are ignored.
    add(1, 0, 3, NOP, 0, 0, 0);
    add(0, 0, 7, NOP, 1, 0, 0);
    add(0, 0, 7, w0,  1, 0, 0);
    add(0, 0, 3, w1,  1, 0, 0);
    add(0, 0, 3, w2,  1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 3, NOP, 1, 0, 0);
    add(0, 0, 3, NOP, 1, 1, 0);
    add(0, 0, 3, NOP, 0, 0, 0);
    run_vecs("frame");

    // Overrun: tick mid-frame, tick+clear together, tick in the frame_done cycle.
    add(1, 0, 3, NOP, 0, 0, 0);
    add(0, 0, 3, NOP, 1, 0, 0);
    add(0, 0, 3, w0,  1, 0, 0);
    add(0, 0, 3, w1,  1, 0, 0);
    add(1, 0, 3, w2,  1, 0, 0);
    add(0, 0, 3, NOP, 1, 0, 1);
    add(1, 1, 3, NOP, 1, 0, 1);
    add(0, 0, 3, NOP, 1, 0, 1);
    add(0, 0, 3, NOP, 1, 0, 1);
    add(1, 0, 3, NOP, 1, 1, 1);
    add(0, 1, 3, NOP, 0, 0, 1);
    add(0, 0, 3, NOP, 0, 0, 0);
    run_vecs("overrun");

    // Zero-length frame, plus a tick landing in its frame_done cycle.
    add(1, 0, 0, NOP, 0, 0, 0);
    add(1, 0, 0, NOP, 0, 1, 0);
    add(0, 1, 0, NOP, 0, 0, 1);
    add(0, 0, 0, NOP, 0, 0, 0);
    run_vecs("zero_len");

    // Host write while running is dropped and flagged.
    @(negedge clk); prog_len = 11'd3; sample_tick = 1'b1;          // cycle T
    @(negedge clk); sample_tick = 1'b0;                            // T+1
    @(negedge clk);                                                // T+2
    prog_wr_en = 1'b1; prog_wr_addr = 10'd2; prog_wr_data = junk;
    @(negedge clk); prog_wr_en = 1'b0;                             // T+3
    check("wr_run.wr_reject_pulse", 32'(wr_reject), 32'd1);
    check("wr_run.word1", 32'(instruction), 32'(w1));
    @(negedge clk);                                                // T+4
    check("wr_run.wr_reject_end", 32'(wr_reject), 32'd0);
    check("wr_run.word2_unchanged", 32'(instruction), 32'(w2));
    repeat (7) @(negedge clk);                                     // T+11
    check("wr_run.idle_after", 32'(frame_active), 32'd0);

    // Write and tick in the same IDLE cycle: the frame sees the new word 0.
    @(negedge clk);                                                // cycle T
    prog_wr_en = 1'b1; prog_wr_addr = 10'd0; prog_wr_data = new0;
    prog_len = 11'd1; sample_tick = 1'b1;
    @(negedge clk); prog_wr_en = 1'b0; sample_tick = 1'b0;         // T+1
    check("wr_tick.no_reject", 32'(wr_reject), 32'd0);
    @(negedge clk);                                                // T+2
    check("wr_tick.new_word0", 32'(instruction), 32'(new0));
    repeat (5) @(negedge clk);                                     // T+7
    check("wr_tick.frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);                                                // T+8

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); prog_len = 11'd3; sample_tick = 1'b1;          // cycle T
    @(negedge clk); sample_tick = 1'b0;                            // T+1
    @(negedge clk);                                                // T+2
    check("rst_mid.word0_before", 32'(instruction), 32'(new0));
    reset = 1'b1;
    #1;
    check("rst_mid.instruction", 32'(instruction), 32'(NOP));
    check("rst_mid.frame_active", 32'(frame_active), 32'd0);
    @(negedge clk); reset = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (frame_done) done_seen = 1'b1;
    end
    check("rst_mid.no_frame_done", 32'(done_seen), 32'd0);
    @(negedge clk); sample_tick = 1'b1;                            // cycle T
    @(negedge clk); sample_tick = 1'b0;                            // T+1
    check("rst_mid.restart_active", 32'(frame_active), 32'd1);
    @(negedge clk);                                                // T+2
    check("rst_mid.restart_word0", 32'(instruction), 32'(new0));
    @(negedge clk);                                                // T+3
    check("rst_mid.restart_word1", 32'(instruction), 32'(w1));
    repeat (8) @(negedge clk);

    // Full depth: 1024 words, prog_len clamps from 1500 to 1024.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      prog_wr_en = 1'b1; prog_wr_addr = 10'(i); prog_wr_data = mk(OP_MAC, i, 0);
    end
    @(negedge clk); prog_wr_en = 1'b0;
    prog_len = 11'd1500; sample_tick = 1'b1;                       // cycle T
    err_cnt = 0; first_done = 0; active_after = 1'b1;
    for (int c = 1; c <= 1032; c++) begin
      @(negedge clk);                                              // T+c
      sample_tick = 1'b0;
      exp_w = (c >= 2 && c <= 1025) ? mk(OP_MAC, c - 2, 0) : NOP;
      if (instruction !== exp_w) err_cnt++;
      if (frame_done === 1'b1 && first_done == 0) first_done = c;
      if (c == 1031) active_after = frame_active;
    end
    check("full.word_mismatches", 32'(err_cnt), 32'd0);
    check("full.frame_done_cycle", 32'(first_done), 32'd1030);
    check("full.idle_after", 32'(active_after), 32'd0);
    check("full.no_overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
